// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ICACHE_SETS     = 8;
    localparam int ICACHE_BLKWORDS = 2;
    // Widest tag (SETS=2); narrower tags are stored zero-extended.
    localparam int ICACHE_TAGW_MAX = 28;

    typedef struct packed {
        logic                             valid;
        logic [ICACHE_TAGW_MAX-1:0]       tag;
        logic [ICACHE_BLKWORDS-1:0][31:0] data;
    } icache_frame_t;

endpackage

// File: rtl/icache_if.sv
// Datapath fetch port plus coherence-controller fill port of the icache.
interface icache_if;

    logic        dp_iREN;
    logic [31:0] dp_iaddr;
    logic        flush;
    logic        dp_ihit;
    logic [31:0] dp_iload;
    logic        cc_iREN;
    logic [31:0] cc_iaddr;
    logic        cc_iwait;
    logic [31:0] cc_iload;

    modport master (
        output dp_iREN, dp_iaddr, flush, cc_iwait, cc_iload,
        input  dp_ihit, dp_iload, cc_iREN, cc_iaddr
    );

    modport slave (
        input  dp_iREN, dp_iaddr, flush, cc_iwait, cc_iload,
        output dp_ihit, dp_iload, cc_iREN, cc_iaddr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped, two-word-block instruction cache with a two-grant fill sequence.
module icache
    import icache_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic     CLK,
    input  logic     nRST,
    icache_if.slave  bus
);

    localparam int IDXW = $clog2(SETS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL0 = 2'd1,
        FILL1 = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    icache_frame_t               r_frames [SETS];
    logic [31:0]                 r_fill_addr;
    logic [31:0]                 r_word0;

    logic [IDXW-1:0]             w_idx;
    logic [IDXW-1:0]             w_fill_idx;
    logic [ICACHE_TAGW_MAX-1:0]  w_tag;
    logic [ICACHE_TAGW_MAX-1:0]  w_fill_tag;
    logic [31:0]                 w_word;
    logic                        w_hit;
    logic                        w_start_fill;
    logic                        w_cap_word0;
    logic                        w_write_line;
    wire                         w_unused = ^bus.dp_iaddr[1:0];

    assign w_idx      = bus.dp_iaddr[2+IDXW:3];
    assign w_tag      = ICACHE_TAGW_MAX'(bus.dp_iaddr >> (3 + IDXW));
    assign w_fill_idx = r_fill_addr[2+IDXW:3];
    assign w_fill_tag = ICACHE_TAGW_MAX'(r_fill_addr >> (3 + IDXW));
    assign w_word     = r_frames[w_idx].data[bus.dp_iaddr[2]];

    // Lookup, fill sequencing and next-state decode.
    always_comb begin
        w_next_state = r_state;
        w_hit        = 1'b0;
        w_start_fill = 1'b0;
        w_cap_word0  = 1'b0;
        w_write_line = 1'b0;
        bus.dp_ihit  = 1'b0;
        bus.dp_iload = 32'd0;
        bus.cc_iREN  = 1'b0;
        bus.cc_iaddr = 32'd0;
        case (r_state)
            IDLE: begin
                w_hit = bus.dp_iREN && !bus.flush && r_frames[w_idx].valid &&
                        (r_frames[w_idx].tag == w_tag);
                bus.dp_ihit  = w_hit;
                bus.dp_iload = w_hit ? w_word : 32'd0;
                if (!bus.flush && bus.dp_iREN && !w_hit) begin
                    w_start_fill = 1'b1;
                    w_next_state = FILL0;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FILL0: begin
                bus.cc_iREN  = 1'b1;
                bus.cc_iaddr = r_fill_addr;
                if (bus.flush) begin
                    w_next_state = IDLE;
                end else if (!bus.cc_iwait) begin
                    w_cap_word0  = 1'b1;
                    w_next_state = FILL1;
                end else begin
                    w_next_state = FILL0;
                end
            end
            FILL1: begin
                bus.cc_iREN  = 1'b1;
                bus.cc_iaddr = r_fill_addr + 32'd4;
                if (bus.flush) begin
                    w_next_state = IDLE;
                end else if (!bus.cc_iwait) begin
                    w_write_line = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = FILL1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, fill registers and the set array; only valid bits are reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_fill_addr <= 32'd0;
            r_word0     <= 32'd0;
            for (int i = 0; i < SETS; i++) begin
                r_frames[i].valid <= 1'b0;
            end
        end else begin
            r_state <= w_next_state;
            if (bus.flush) begin
                for (int i = 0; i < SETS; i++) begin
                    r_frames[i].valid <= 1'b0;
                end
            end else if (w_write_line) begin
                r_frames[w_fill_idx] <= '{valid: 1'b1, tag: w_fill_tag,
                                          data: {bus.cc_iload, r_word0}};
            end
            if (w_start_fill) begin
                r_fill_addr <= {bus.dp_iaddr[31:3], 3'b000};
            end
            if (w_cap_word0) begin
                r_word0 <= bus.cc_iload;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: block-level cache model, latency-programmable controller.
module tb_icache;

    localparam int SETS = 8;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    icache_if bus ();

    icache #(.SETS(SETS)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    // ---------------- controller: grants after ctl_lat request cycles
    int          ctl_lat     = 2;
    logic        force_grant = 1'b0;
    int          r_cnt;
    logic [31:0] r_garbage;
    logic        grant;

    always_comb begin
        grant        = bus.cc_iREN && (r_cnt >= ctl_lat - 1);
        bus.cc_iwait = !(grant || force_grant);
        bus.cc_iload = grant ? mem_word(bus.cc_iaddr) : r_garbage;
    end

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) r_cnt <= 0;
        else if (!bus.cc_iREN || grant) r_cnt <= 0;
        else r_cnt <= r_cnt + 1;
        r_garbage <= $urandom();
    end

    // ---------------- behavioural model: which blocks are resident, what is in flight
    bit          m_v    [SETS];
    logic [31:0] m_base [SETS];
    logic [31:0] m_d0   [SETS];
    logic [31:0] m_d1   [SETS];
    bit          m_busy = 1'b0;
    int          m_got  = 0;
    logic [31:0] m_fbase = 32'd0;
    logic [31:0] m_w0    = 32'd0;

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 3) & 32'(SETS - 1));
    endfunction

    function automatic bit model_hit();
        int s;
        s = set_of(bus.dp_iaddr);
        return !m_busy && bus.dp_iREN && !bus.flush && m_v[s] &&
               (m_base[s] == {bus.dp_iaddr[31:3], 3'b000});
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_busy = 1'b0;
            m_got  = 0;
            for (int i = 0; i < SETS; i++) m_v[i] = 1'b0;
        end else if (bus.flush) begin
            m_busy = 1'b0;
            for (int i = 0; i < SETS; i++) m_v[i] = 1'b0;
        end else if (m_busy) begin
            if (!bus.cc_iwait) begin
                if (m_got == 0) begin
                    m_w0  = bus.cc_iload;
                    m_got = 1;
                end else begin
                    m_v[set_of(m_fbase)]    = 1'b1;
                    m_base[set_of(m_fbase)] = m_fbase;
                    m_d0[set_of(m_fbase)]   = m_w0;
                    m_d1[set_of(m_fbase)]   = bus.cc_iload;
                    m_busy = 1'b0;
                end
            end
        end else if (bus.dp_iREN && !model_hit()) begin
            m_busy  = 1'b1;
            m_got   = 0;
            m_fbase = {bus.dp_iaddr[31:3], 3'b000};
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge CLK) begin
        bit          e_hit;
        logic [31:0] e_load;
        int          s;
        s      = set_of(bus.dp_iaddr);
        e_hit  = model_hit();
        e_load = !e_hit ? 32'd0 : (bus.dp_iaddr[2] ? m_d1[s] : m_d0[s]);
        chk("model_ihit",   32'(bus.dp_ihit), 32'(e_hit));
        chk("model_iload",  bus.dp_iload,     e_load);
        chk("model_ccren",  32'(bus.cc_iREN), 32'(m_busy));
        chk("model_ccaddr", bus.cc_iaddr,     m_busy ? m_fbase + 32'(4 * m_got) : 32'd0);
    end

    // ---------------- directed stimulus
    task automatic go();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_hit(input logic [31:0] a, output int n);
        bit done;
        bus.dp_iREN  = 1'b1;
        bus.dp_iaddr = a;
        n    = 0;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge CLK);
            if (bus.dp_ihit) begin
                done = 1'b1;
            end else begin
                n++;
                go();
            end
        end
    endtask

    logic [31:0] pool [10] = '{32'h40, 32'h44, 32'h80, 32'h84, 32'h100,
                               32'h208, 32'h20C, 32'h310, 32'h48, 32'h4C};

    initial begin
        int n;
        bus.dp_iREN  = 1'b0;
        bus.dp_iaddr = 32'd0;
        bus.flush    = 1'b0;
        @(negedge CLK);
        chk("rst_ihit",  32'(bus.dp_ihit), 32'd0);
        chk("rst_ccren", 32'(bus.cc_iREN), 32'd0);
        go(); go();
        nRST = 1'b1;

        // cold miss at 0x40, latency 2
        bus.dp_iREN  = 1'b1;
        bus.dp_iaddr = 32'h40;
        @(negedge CLK);
        chk("cold_c0_hit",   32'(bus.dp_ihit), 32'd0);
        chk("cold_c0_ren",   32'(bus.cc_iREN), 32'd0);
        go(); @(negedge CLK);
        chk("cold_c1_ren",   32'(bus.cc_iREN), 32'd1);
        chk("cold_c1_addr",  bus.cc_iaddr, 32'h40);
        go(); @(negedge CLK);
        chk("cold_c2_addr",  bus.cc_iaddr, 32'h40);
        go(); @(negedge CLK);
        chk("cold_c3_addr",  bus.cc_iaddr, 32'h44);
        go(); @(negedge CLK);
        chk("cold_c4_hit",   32'(bus.dp_ihit), 32'd0);
        go(); @(negedge CLK);
        chk("cold_c5_hit",   32'(bus.dp_ihit), 32'd1);
        chk("cold_c5_load",  bus.dp_iload, 32'hC09E_0040);
        chk("cold_c5_ren",   32'(bus.cc_iREN), 32'd0);

        // spatial hit on the second word
        go();
        bus.dp_iaddr = 32'h44;
        @(negedge CLK);
        chk("spatial_hit",   32'(bus.dp_ihit), 32'd1);
        chk("spatial_load",  bus.dp_iload, 32'hC09A_0044);
        chk("spatial_ren",   32'(bus.cc_iREN), 32'd0);

        // conflict on set 0, then 0x40 must refill
        go(); wait_hit(32'h80, n);
        chk("conflict_lat",  32'(n), 32'd5);
        chk("conflict_load", bus.dp_iload, 32'hC05E_0080);
        go(); wait_hit(32'h40, n);
        chk("evicted_lat",   32'(n), 32'd5);

        // other controller latencies: penalty 2L+1
        ctl_lat = 1;
        go(); wait_hit(32'h208, n);
        chk("lat1_penalty",  32'(n), 32'd3);
        ctl_lat = 4;
        go(); wait_hit(32'h310, n);
        chk("lat4_penalty",  32'(n), 32'd9);
        ctl_lat = 2;

        // stray grants while idle are ignored
        go();
        force_grant  = 1'b1;
        bus.dp_iaddr = 32'h44;
        @(negedge CLK);
        chk("stray_grant_hit", 32'(bus.dp_ihit), 32'd1);
        go();
        bus.dp_iREN = 1'b0;
        go();
        force_grant = 1'b0;
        bus.dp_iREN = 1'b1;
        bus.dp_iaddr = 32'h40;
        @(negedge CLK);
        chk("stray_grant_keep", 32'(bus.dp_ihit), 32'd1);

        // flush in idle, then flush during FILL1
        go();
        bus.flush = 1'b1;
        @(negedge CLK);
        chk("flush_idle_hit", 32'(bus.dp_ihit), 32'd0);
        go();
        bus.flush = 1'b0;
        @(negedge CLK);
        chk("flushed_miss",   32'(bus.dp_ihit), 32'd0);
        go(); go(); go();
        bus.flush = 1'b1;
        @(negedge CLK);
        chk("fill1_addr",     bus.cc_iaddr, 32'h44);
        go();
        bus.flush   = 1'b0;
        bus.dp_iREN = 1'b0;
        @(negedge CLK);
        chk("abort_ren",      32'(bus.cc_iREN), 32'd0);
        go(); wait_hit(32'h40, n);
        chk("refetch_lat",    32'(n), 32'd5);

        // address change during FILL0 is ignored
        go();
        bus.dp_iaddr = 32'h48;
        go();
        bus.dp_iREN  = 1'b0;
        bus.dp_iaddr = 32'h100;
        @(negedge CLK);
        chk("latched_addr0",  bus.cc_iaddr, 32'h48);
        go(); go();
        @(negedge CLK);
        chk("latched_addr1",  bus.cc_iaddr, 32'h4C);
        go(); go();
        bus.dp_iREN = 1'b1;
        @(negedge CLK);
        chk("new_addr_miss",  32'(bus.dp_ihit), 32'd0);
        go(); wait_hit(32'h100, n);
        chk("new_addr_lat",   32'(n), 32'd4);
        go();
        bus.dp_iaddr = 32'h4C;
        @(negedge CLK);
        chk("latched_line",   bus.dp_iload, 32'hC092_004C);

        // reset pulse mid-fill
        go();
        bus.dp_iaddr = 32'h208;
        go(); go();
        nRST = 1'b0;
        @(negedge CLK);
        chk("rstmid_ihit",   32'(bus.dp_ihit),  32'd0);
        chk("rstmid_iload",  bus.dp_iload,      32'd0);
        chk("rstmid_ren",    32'(bus.cc_iREN),  32'd0);
        chk("rstmid_addr",   bus.cc_iaddr,      32'd0);
        go();
        nRST = 1'b1;
        bus.dp_iaddr = 32'h48;
        @(negedge CLK);
        chk("post_rst_miss", 32'(bus.dp_ihit), 32'd0);
        go(); wait_hit(32'h48, n);
        chk("post_rst_lat",  32'(n), 32'd4);

        // random mix, model-checked every cycle
        for (int i = 0; i < 400; i++) begin
            go();
            bus.dp_iREN  = ($urandom_range(0, 3) != 0);
            bus.dp_iaddr = pool[$urandom_range(0, 9)];
            bus.flush    = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 15) == 0) ctl_lat = int'($urandom_range(1, 3));
        end
        go();
        bus.dp_iREN = 1'b0;
        bus.flush   = 1'b0;
        go(); go();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
